// File: rtl/param_factorial.sv
// param_factorial: sequential n! engine, one multiply per clock.
// On overflow it either wraps modulo 2^WIDTH or saturates to all-ones.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first start after reset
// CALC  | multiplying accumulator by i while i <= n
// DONE  | result on factorial, ready held until the next accepted start
module param_factorial #(
    parameter int WIDTH    = 32,
    parameter int IN_WIDTH = 8,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [IN_WIDTH-1:0] val,
    output logic                busy,
    output logic                ready,
    output logic [WIDTH-1:0]    factorial,
    output logic                overflow
);

    // The product is exact at this width, so every bit at or above WIDTH
    // is a true overflow bit.
    localparam int PW = WIDTH + IN_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] n_q, n_d;
    logic [IN_WIDTH:0]   i_q, i_d;
    logic [WIDTH-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0]    fact_q, fact_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                ovf_q, ovf_d;

    logic [PW-1:0]       prod;
    logic                prod_ovf;

    assign prod     = PW'(acc_q) * PW'(i_q);
    assign prod_ovf = |prod[PW-1:WIDTH];

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        acc_d   = acc_q;
        fact_d  = fact_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = CALC;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    ovf_d   = 1'b0;
                    n_d     = val;
                    acc_d   = WIDTH'(1);
                    i_d     = (IN_WIDTH + 1)'(2);
                end
            end
            CALC: begin
                if (i_q <= {1'b0, n_q}) begin
                    acc_d = prod[WIDTH-1:0];
                    i_d   = i_q + 1'b1;
                    if (prod_ovf) begin
                        ovf_d = 1'b1;
                        if (SATURATE != 0) begin
                            state_d = DONE;
                            fact_d  = '1;
                            ready_d = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end
                end else begin
                    state_d = DONE;
                    fact_d  = acc_q;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            acc_q   <= '0;
            fact_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            acc_q   <= acc_d;
            fact_q  <= fact_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign ready     = ready_q;
    assign factorial = fact_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_param_factorial.sv
// Directed bench for param_factorial: a wrapping instance and a saturating
// instance share one clock and one reset.
module tb_param_factorial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [7:0]  val0 = '0, val1 = '0;
    logic        busy0, busy1, ready0, ready1, ovf0, ovf1;
    logic [31:0] fact0, fact1;

    int          total = 0;
    int          passed = 0;
    logic [31:0] prev0 = '0, prev1 = '0;

    always #5 clk = ~clk;

    param_factorial #(.WIDTH(32), .IN_WIDTH(8), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start0), .val(val0),
        .busy(busy0), .ready(ready0), .factorial(fact0), .overflow(ovf0)
    );

    param_factorial #(.WIDTH(32), .IN_WIDTH(8), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start1), .val(val1),
        .busy(busy1), .ready(ready1), .factorial(fact1), .overflow(ovf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy0 : busy1;
    endfunction
    function automatic logic get_ready(input int sel);
        return (sel == 0) ? ready0 : ready1;
    endfunction
    function automatic logic get_ovf(input int sel);
        return (sel == 0) ? ovf0 : ovf1;
    endfunction
    function automatic logic [31:0] get_fact(input int sel);
        return (sel == 0) ? fact0 : fact1;
    endfunction

    task automatic drive_start(input int sel, input logic [7:0] v);
        if (sel == 0) begin start0 = 1'b1; val0 = v; end
        else begin start1 = 1'b1; val1 = v; end
    endtask

    // Called #1 after an edge; start is accepted on the next edge.
    // pulse_at >= 0 raises a stray start (val=3) that many cycles in.
    task automatic run(input int sel, input logic [7:0] v, input int lat,
                       input logic [31:0] ef, input logic eo,
                       input int pulse_at, input string tag);
        int cnt;
        bit done;
        logic [31:0] prev;
        prev = (sel == 0) ? prev0 : prev1;
        drive_start(sel, v);
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        chk({tag, "_busy_on_accept"}, 64'(get_busy(sel)), 64'd1);
        chk({tag, "_ready_clear"}, 64'(get_ready(sel)), 64'd0);
        chk({tag, "_ovf_clear"}, 64'(get_ovf(sel)), 64'd0);
        cnt = 0;
        done = 0;
        while (!done && cnt < 300) begin
            if (cnt == pulse_at) drive_start(sel, 8'd3);
            @(posedge clk); #1;
            start0 = 1'b0; start1 = 1'b0;
            cnt++;
            if (get_ready(sel)) done = 1;
            else chk({tag, "_fact_hold"}, 64'(get_fact(sel)), 64'(prev));
        end
        chk({tag, "_latency"}, 64'(cnt), 64'(lat));
        chk({tag, "_factorial"}, 64'(get_fact(sel)), 64'(ef));
        chk({tag, "_overflow"}, 64'(get_ovf(sel)), 64'(eo));
        chk({tag, "_busy_done"}, 64'(get_busy(sel)), 64'd0);
        if (sel == 0) prev0 = ef; else prev1 = ef;
    endtask

    initial begin
        #2;
        chk("reset_busy", 64'(busy0), 64'd0);
        chk("reset_ready", 64'(ready0), 64'd0);
        chk("reset_fact", 64'(fact0), 64'd0);
        chk("reset_ovf", 64'(ovf0), 64'd0);
        chk("reset_sat_fact", 64'(fact1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run(0, 8'd5,  5,  32'd120,        1'b0, -1, "wrap_n5");
        run(0, 8'd0,  1,  32'd1,          1'b0, -1, "wrap_n0");
        run(0, 8'd1,  1,  32'd1,          1'b0, -1, "wrap_n1");
        run(0, 8'd12, 12, 32'd479001600,  1'b0, -1, "wrap_n12");
        run(0, 8'd13, 13, 32'd1932053504, 1'b1, -1, "wrap_n13");
        run(0, 8'd16, 16, 32'h77758000,   1'b1, -1, "wrap_n16");
        run(0, 8'd2,  2,  32'd2,          1'b0, -1, "wrap_n2");

        run(1, 8'd16, 12, 32'hFFFFFFFF,   1'b1, -1, "sat_n16");
        run(1, 8'd12, 12, 32'd479001600,  1'b0, -1, "sat_n12");
        run(1, 8'd5,  5,  32'd120,        1'b0, -1, "sat_n5");

        // Stray start mid-CALC is ignored, then restart straight from DONE.
        run(0, 8'd10, 10, 32'd3628800,    1'b0, 3,  "ignore_n10");
        run(0, 8'd3,  3,  32'd6,          1'b0, -1, "b2b_n3");

        // Reset in the middle of a computation.
        @(posedge clk); #1;
        drive_start(0, 8'd9);
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_busy", 64'(busy0), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_ready", 64'(ready0), 64'd0);
        chk("rst_fact", 64'(fact0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_sat_fact", 64'(fact1), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        prev0 = '0;
        prev1 = '0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_result_ready", 64'(ready0), 64'd0);
        chk("no_result_busy", 64'(busy0), 64'd0);
        chk("no_result_fact", 64'(fact0), 64'd0);
        run(0, 8'd4, 4, 32'd24, 1'b0, -1, "post_rst_n4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // busy and ready must never be high together on either instance.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy0 && ready0) $error("FAIL wrap_busy_ready_both observed=1 expected=0");
            if (busy1 && ready1) $error("FAIL sat_busy_ready_both observed=1 expected=0");
        end
    end

endmodule

// File: doc/param_factorial.md
PARAM_FACTORIAL -- requirements
Module: param_factorial

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32: result width in bits, at least 8.
- IN_WIDTH, 8: operand width in bits, from 2 to 16.
- SATURATE, 0: overflow mode; 0 = wrap (modulo 2^WIDTH), 1 = saturate to all-ones.

REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when not busy.
- val  in  IN_WIDTH  operand n, unsigned; captured on an accepted start.
- busy  out  1  computation in progress.
- ready  out  1  result valid; sticky until the next accepted start.
- factorial  out  WIDTH  result n! (wrapped or saturated).
- overflow  out  1  true n! exceeded 2^WIDTH-1; valid with ready.

REQ-003 All outputs SHALL be driven directly from registers.

Function
REQ-004 The FSM SHALL have states IDLE, CALC and DONE; reset enters IDLE.
REQ-005 In IDLE or DONE, start=1 at a rising edge SHALL:
- enter CALC, set busy=1, clear ready and overflow;
- load n=val, accumulator=1, multiplier counter i=2.
REQ-006 start SHALL be ignored while busy=1; the in-flight computation is unaffected.
REQ-007 In CALC, each edge with i<=n SHALL:
- set accumulator = low WIDTH bits of (accumulator*i), using the full 2*WIDTH-bit product;
- increment i.
REQ-008 Counter i SHALL be IN_WIDTH+1 bits, so n = 2^IN_WIDTH-1 terminates without wrap.
REQ-009 In CALC, the edge with i>n SHALL enter DONE, copy the accumulator to factorial, set ready=1 and busy=0.
REQ-010 If the upper WIDTH bits of any product are nonzero, overflow SHALL be set and stay set until the next accepted start.
REQ-011 SATURATE=1: the edge that detects overflow SHALL enter DONE immediately with factorial = all-ones, ready=1, overflow=1.
REQ-012 SATURATE=0: computation SHALL continue to completion, giving n! mod 2^WIDTH with overflow=1.
REQ-013 Latency, without early saturation, SHALL be max(n,1) cycles from the accepting edge to the ready=1 edge.
- n=0 and n=1 SHALL give factorial=1 after 1 cycle.
REQ-014 factorial SHALL hold its previous result while busy and change only on entry to DONE.
REQ-015 A start accepted in DONE, in the same cycle as ready=1, SHALL be legal; ready drops on the next edge.
REQ-016 busy and ready SHALL never be 1 simultaneously.

Reset
REQ-017 rst_n=0 SHALL immediately force: IDLE, busy=0, ready=0, overflow=0, factorial=0, accumulator=0, counter=0.
REQ-018 Reset during CALC SHALL abandon the computation; no result is produced after release.
REQ-019 After rst_n rises, the first rising edge SHALL accept start.

Verification (WIDTH=32, IN_WIDTH=8)
REQ-020 start with val=5, SATURATE=0 -> ready=1 exactly 5 cycles later, factorial=120, overflow=0.
REQ-021 val=0, then separately val=1 -> each gives factorial=1 after 1 cycle, overflow=0.
REQ-022 Boundary cases, SATURATE=0:
- val=12 -> factorial=479001600, overflow=0, after 12 cycles.
- val=13 -> overflow=1, after 13 cycles.
REQ-023 val=16:
- SATURATE=0 -> factorial=2004189184 (0x77758000), overflow=1, after 16 cycles.
- SATURATE=1 -> factorial=0xFFFFFFFF, overflow=1, ready after 12 cycles.
REQ-024 start val=10, then start val=3 pulsed mid-CALC -> second start ignored, factorial=3628800.
- Then start val=3 in the DONE cycle -> ready drops next edge, factorial=6 three cycles after acceptance.
REQ-025 rst_n low for 1 cycle mid-CALC (val=9) -> all outputs 0 immediately, FSM in IDLE.
- A new start val=4 then gives factorial=24 after 4 cycles.
